// File: rtl/rv_pkg.sv
// Shared definitions for the RISC pipeline: datapath widths, ALU op codes,
// write-back select encodings and the EX-stage squash FSM states.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic {
        EX_RUN,
        EX_SHADOW
    } ex_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU for the EX stage; unknown op codes produce zero,
// which therefore also raises the zero flag.
module alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_ADD: result = SrcA + SrcB;
            ALU_SUB: result = SrcA - SrcB;
            ALU_AND: result = SrcA & SrcB;
            ALU_OR:  result = SrcA | SrcB;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch resolution, EX/MEM pipeline register, one-cycle
// wrong-path squash after a taken branch and saturating branch counters.
module execute_stage
    import rv_pkg::*;
#(
    parameter int CNTW = 16
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] IMM,
    input  logic [REGW-1:0] rd_in,
    input  logic [2:0]      ALUControl,
    input  logic            ALUSrc,
    input  logic [1:0]      ResultSrc,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            BF,
    output logic            zeroFlag,
    output logic            take_branch,
    output logic [XLEN-1:0] ALUResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [REGW-1:0] rd_M,
    output logic [1:0]      ResultSrc_M,
    output logic            MemWrite_M,
    output logic            RegWrite_M,
    output logic [CNTW-1:0] br_taken_cnt,
    output logic [CNTW-1:0] br_total_cnt
);

    ex_state_e       state_q;
    ex_state_e       state_d;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            squash;
    logic            kill_ctrl;

    assign src_b = ALUSrc ? IMM : B;

    alu u_alu (
        .SrcA       (A),
        .SrcB       (src_b),
        .ALUControl (ALUControl),
        .result     (alu_result),
        .zero       (zeroFlag)
    );

    assign squash      = (state_q == EX_SHADOW);
    assign take_branch = BF & zeroFlag & ~squash & ~stall;
    // Branches and squashed slots must never write the register file or memory.
    assign kill_ctrl   = BF | squash;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EX_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EX_RUN:    if (take_branch) state_d = EX_SHADOW;
            EX_SHADOW: if (!stall)      state_d = EX_RUN;
            default:   state_d = EX_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResult_M <= '0;
            WriteData_M <= '0;
            rd_M        <= '0;
            ResultSrc_M <= '0;
            MemWrite_M  <= 1'b0;
            RegWrite_M  <= 1'b0;
        end else if (!stall) begin
            ALUResult_M <= alu_result;
            WriteData_M <= B;
            rd_M        <= rd_in;
            ResultSrc_M <= ResultSrc;
            MemWrite_M  <= MemWrite & ~kill_ctrl;
            RegWrite_M  <= RegWrite & ~kill_ctrl;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_taken_cnt <= '0;
            br_total_cnt <= '0;
        end else if (!stall) begin
            if (BF && !squash && (br_total_cnt != '1)) begin
                br_total_cnt <= br_total_cnt + CNTW'(1);
            end
            if (take_branch && (br_taken_cnt != '1)) begin
                br_taken_cnt <= br_taken_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the EX stage.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] IMM;
    logic [4:0]  rd_in;
    logic [2:0]  ALUControl;
    logic        ALUSrc;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic        RegWrite;
    logic        BF;
    logic        zeroFlag;
    logic        take_branch;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [4:0]  rd_M;
    logic [1:0]  ResultSrc_M;
    logic        MemWrite_M;
    logic        RegWrite_M;
    logic [15:0] br_taken_cnt;
    logic [15:0] br_total_cnt;

    int nAsserts = 0;
    int nFails   = 0;
    bit doChecks = 1;

    // Reference model state
    bit          mShadow;
    int          mTaken;
    int          mTotal;
    bit          mDataValid;
    logic [31:0] mAlu;
    logic [31:0] mWd;
    logic [4:0]  mRd;
    logic [1:0]  mRs;
    bit          mMw;
    bit          mRw;
    logic [31:0] mRes;
    bit          mTb;

    execute_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .A            (A),
        .B            (B),
        .IMM          (IMM),
        .rd_in        (rd_in),
        .ALUControl   (ALUControl),
        .ALUSrc       (ALUSrc),
        .ResultSrc    (ResultSrc),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .BF           (BF),
        .zeroFlag     (zeroFlag),
        .take_branch  (take_branch),
        .ALUResult_M  (ALUResult_M),
        .WriteData_M  (WriteData_M),
        .rd_M         (rd_M),
        .ResultSrc_M  (ResultSrc_M),
        .MemWrite_M   (MemWrite_M),
        .RegWrite_M   (RegWrite_M),
        .br_taken_cnt (br_taken_cnt),
        .br_total_cnt (br_total_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mShadow    = 0;
        mTaken     = 0;
        mTotal     = 0;
        mDataValid = 1;
        mAlu       = '0;
        mWd        = '0;
        mRd        = '0;
        mRs        = '0;
        mMw        = 0;
        mRw        = 0;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".MemWrite_M"}, 32'(MemWrite_M), 32'(mMw));
        checkOutput({tag, ".RegWrite_M"}, 32'(RegWrite_M), 32'(mRw));
        checkOutput({tag, ".br_taken_cnt"}, 32'(br_taken_cnt), mTaken);
        checkOutput({tag, ".br_total_cnt"}, 32'(br_total_cnt), mTotal);
        if (mDataValid) begin
            checkOutput({tag, ".ALUResult_M"}, ALUResult_M, mAlu);
            checkOutput({tag, ".WriteData_M"}, WriteData_M, mWd);
            checkOutput({tag, ".rd_M"}, 32'(rd_M), 32'(mRd));
            checkOutput({tag, ".ResultSrc_M"}, 32'(ResultSrc_M), 32'(mRs));
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] op,
                                 input logic src, input logic [1:0] rs, input logic mw,
                                 input logic rw, input logic bf);
        stall      = st;
        A          = a;
        B          = b;
        IMM        = imm;
        rd_in      = rd;
        ALUControl = op;
        ALUSrc     = src;
        ResultSrc  = rs;
        MemWrite   = mw;
        RegWrite   = rw;
        BF         = bf;
        #1;
        mRes = aluRef(a, src ? imm : b, op);
        mTb  = bf && (mRes == 32'd0) && !mShadow && !st;
    endtask

    // One instruction slot: drive, check combinational outputs, clock, check EX/MEM.
    task automatic doCycle(input string tag, input logic st, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] op,
                           input logic src, input logic [1:0] rs, input logic mw,
                           input logic rw, input logic bf);
        applyStimulus(st, a, b, imm, rd, op, src, rs, mw, rw, bf);
        if (doChecks) begin
            checkOutput({tag, ".zeroFlag"}, 32'(zeroFlag), 32'(mRes == 32'd0));
            checkOutput({tag, ".take_branch"}, 32'(take_branch), 32'(mTb));
        end
        @(posedge clk);
        #1;
        if (!st) begin
            if (bf && !mShadow && mTotal < 65535) mTotal++;
            if (mTb && mTaken < 65535) mTaken++;
            mDataValid = !mShadow;
            mAlu       = mRes;
            mWd        = b;
            mRd        = rd;
            mRs        = rs;
            mMw        = mw && !bf && !mShadow;
            mRw        = rw && !bf && !mShadow;
            mShadow    = mShadow ? 1'b0 : mTb;
        end
        if (doChecks) checkRegs(tag);
    endtask

    initial begin
        rst = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkRegs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] add with immediate");
        doCycle("add", 0, 5, 99, 7, 3, 3'b000, 1, 2'b00, 0, 1, 0);
        checkOutput("add.direct", ALUResult_M, 32'd12);
        checkOutput("add.rd", 32'(rd_M), 32'd3);
        checkOutput("add.rw", 32'(RegWrite_M), 32'd1);

        $display("[TB] sub wrap and slt");
        doCycle("subwrap", 0, 0, 1, 0, 4, 3'b001, 0, 2'b00, 0, 1, 0);
        checkOutput("subwrap.direct", ALUResult_M, 32'hFFFF_FFFF);
        doCycle("slt", 0, 32'hFFFF_FFFF, 1, 0, 5, 3'b101, 0, 2'b00, 0, 1, 0);
        checkOutput("slt.direct", ALUResult_M, 32'd1);
        doCycle("undef", 0, 8, 3, 0, 6, 3'b111, 0, 2'b00, 1, 1, 0);

        $display("[TB] taken beq then bubble");
        doCycle("beq", 0, 9, 9, 0, 0, 3'b001, 0, 2'b00, 0, 1, 1);
        checkOutput("beq.rw", 32'(RegWrite_M), 32'd0);
        doCycle("bubble", 0, 1, 2, 0, 7, 3'b000, 0, 2'b01, 1, 1, 0);
        checkOutput("bubble.rw", 32'(RegWrite_M), 32'd0);
        checkOutput("bubble.taken", 32'(br_taken_cnt), 32'd1);
        checkOutput("bubble.total", 32'(br_total_cnt), 32'd1);

        $display("[TB] branch inside shadow");
        doCycle("beq2a", 0, 4, 4, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        doCycle("beq2b", 0, 6, 6, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        checkOutput("shadow.taken", 32'(br_taken_cnt), 32'd2);
        checkOutput("shadow.total", 32'(br_total_cnt), 32'd2);

        $display("[TB] stall hold");
        doCycle("prestall", 0, 10, 20, 0, 9, 3'b000, 0, 2'b10, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            doCycle("stall", 1, $urandom, $urandom, $urandom, 5'($urandom), 3'b010, 0, 2'b01, 0, 1, 0);
        end
        checkOutput("stall.alu", ALUResult_M, 32'd30);
        doCycle("stallbeq", 1, 3, 3, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        doCycle("unstall", 0, 2, 2, 0, 1, 3'b011, 0, 2'b00, 0, 1, 0);
        checkOutput("unstall.rw", 32'(RegWrite_M), 32'd1);

        $display("[TB] async reset in shadow");
        doCycle("prereset", 0, 7, 7, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkRegs("midreset");
        #1;
        rst = 1'b1;
        doCycle("postreset", 0, 1, 1, 0, 2, 3'b000, 0, 2'b00, 0, 1, 0);
        checkOutput("postreset.rw", 32'(RegWrite_M), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? ra : $urandom;
            doCycle("rand", ($urandom_range(0, 4) == 0), ra, rb, $urandom_range(0, 15) - 8,
                    5'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] total counter saturation");
        doChecks = 0;
        for (int i = 0; i < 65540; i++) begin
            doCycle("sat", 0, 1, 2, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        end
        doChecks = 1;
        doCycle("satend", 0, 1, 2, 0, 0, 3'b001, 0, 2'b00, 0, 0, 1);
        checkOutput("sat.total", 32'(br_total_cnt), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
